// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: shared types and constants for the UART receive frame checker.
//   rx_state_e - frame checker FSM states (IDLE, START, DATA, PARITY, STOP, DONE)
//   PAR_EVEN / PAR_ODD - encodings of the par_typ input
//   ERR_CNT_W - width of the optional error-frame counter
//   sat_inc() - saturating increment for that counter
package uart_rx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    DONE
  } rx_state_e;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  localparam int ERR_CNT_W = 8;

  function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/uart_rx_par_calc.sv
// uart_rx_par_calc: combinational parity generator, shared by the RX and TX sides.
// Ports:
//   i_data    [DATA_WIDTH-1:0] data word
//   i_par_typ                  PAR_EVEN or PAR_ODD
//   o_par                      parity bit that belongs with i_data
module uart_rx_par_calc
  import uart_rx_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_par_typ,
  output logic                  o_par
);

  assign o_par = (^i_data) ^ (i_par_typ == PAR_ODD);

endmodule

// File: rtl/uart_rx_frame_check.sv
// uart_rx_frame_check: FSM-driven UART frame checker (start, data, parity, stop).
// Consumes one voted bit per bit_vld strobe, deserialises LSB first, flags start
// glitch / parity error / stop error and hands the word to the RX output stage.
// Parameters: DATA_WIDTH (5..9), STOP_BITS (1 or 2).
// Ports:
//   CLK, RST_n          clock, asynchronous active-low reset
//   frame_en            starts a frame from IDLE; low mid-frame aborts it
//   bit_vld             strobe qualifying sampled_bit
//   sampled_bit         voted line value
//   par_en, par_typ     parity present / odd parity, latched at frame start
//   p_data              last error-free word
//   data_valid          one-cycle pulse on an error-free frame
//   strt_glitch         start bit sampled high (sticky until next frame start)
//   par_err             parity mismatch (sticky until next frame start)
//   stop_err            a stop bit sampled low (sticky until next frame start)
//   busy                FSM not in IDLE
//   err_cnt             saturating count of errored frames, only when
//                       UART_RX_ERR_CNT_EN is defined
module uart_rx_frame_check
  import uart_rx_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int STOP_BITS  = 1
) (
  input  logic                  CLK,
  input  logic                  RST_n,
  input  logic                  frame_en,
  input  logic                  bit_vld,
  input  logic                  sampled_bit,
  input  logic                  par_en,
  input  logic                  par_typ,
  output logic [DATA_WIDTH-1:0] p_data,
  output logic                  data_valid,
  output logic                  strt_glitch,
  output logic                  par_err,
  output logic                  stop_err,
  output logic                  busy
`ifdef UART_RX_ERR_CNT_EN
  ,
  output logic [ERR_CNT_W-1:0]  err_cnt
`endif
);

  localparam int CNT_W = $clog2(DATA_WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(DATA_WIDTH - 1);
  localparam logic [CNT_W-1:0] LAST_STOP = CNT_W'(STOP_BITS - 1);

  rx_state_e r_state, w_state_nxt;
  logic [CNT_W-1:0]      r_cnt;
  logic [DATA_WIDTH-1:0] r_shift;
  logic [DATA_WIDTH-1:0] r_p_data;
  logic r_par_en, r_par_typ;
  logic r_data_valid, r_strt_glitch, r_par_err, r_stop_err;
  logic w_par, w_flags;
  logic w_start, w_glitch, w_shift, w_par_chk, w_stop_chk, w_load;

  assign w_flags     = r_strt_glitch | r_par_err | r_stop_err;
  assign p_data      = r_p_data;
  assign data_valid  = r_data_valid;
  assign strt_glitch = r_strt_glitch;
  assign par_err     = r_par_err;
  assign stop_err    = r_stop_err;
  assign busy        = (r_state != IDLE);

  // Expected parity bit over the received word
  uart_rx_par_calc #(.DATA_WIDTH(DATA_WIDTH)) u_par_calc (
    .i_data   (r_shift),
    .i_par_typ(r_par_typ),
    .o_par    (w_par)
  );

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_glitch    = 1'b0;
    w_shift     = 1'b0;
    w_par_chk   = 1'b0;
    w_stop_chk  = 1'b0;
    w_load      = 1'b0;
    // Dropping frame_en abandons the frame from any state, DONE included
    if (r_state != IDLE && !frame_en) begin
      w_state_nxt = IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          w_start     = frame_en;
          w_state_nxt = frame_en ? START : IDLE;
        end
        START: if (bit_vld) begin
          w_glitch    = sampled_bit;
          w_state_nxt = sampled_bit ? IDLE : DATA;
        end
        DATA: if (bit_vld) begin
          w_shift = 1'b1;
          if (r_cnt == LAST_DATA) w_state_nxt = r_par_en ? PARITY : STOP;
        end
        PARITY: if (bit_vld) begin
          w_par_chk   = 1'b1;
          w_state_nxt = STOP;
        end
        STOP: if (bit_vld) begin
          w_stop_chk = 1'b1;
          if (r_cnt == LAST_STOP) w_state_nxt = DONE;
        end
        DONE: begin
          w_load      = !w_flags;
          w_state_nxt = IDLE;
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      r_cnt         <= '0;
      r_shift       <= '0;
      r_p_data      <= '0;
      r_par_en      <= 1'b0;
      r_par_typ     <= 1'b0;
      r_data_valid  <= 1'b0;
      r_strt_glitch <= 1'b0;
      r_par_err     <= 1'b0;
      r_stop_err    <= 1'b0;
    end else begin
      // Counter restarts on every state change, so it never needs to wrap
      r_cnt        <= (w_state_nxt != r_state) ? '0 : r_cnt + CNT_W'(w_shift | w_stop_chk);
      r_data_valid <= w_load;
      if (w_shift) r_shift <= {sampled_bit, r_shift[DATA_WIDTH-1:1]};
      if (w_load) r_p_data <= r_shift;
      if (w_start) begin
        r_par_en      <= par_en;
        r_par_typ     <= par_typ;
        r_strt_glitch <= 1'b0;
        r_par_err     <= 1'b0;
        r_stop_err    <= 1'b0;
      end else begin
        if (w_glitch) r_strt_glitch <= 1'b1;
        if (w_par_chk && (w_par ^ sampled_bit)) r_par_err <= 1'b1;
        if (w_stop_chk && !sampled_bit) r_stop_err <= 1'b1;
      end
    end
  end

`ifdef UART_RX_ERR_CNT_EN
  logic [ERR_CNT_W-1:0] r_err_cnt;

  // Errored frames are counted as they leave DONE; start glitches as they abort
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) r_err_cnt <= '0;
    else if (w_glitch || (r_state == DONE && w_flags)) r_err_cnt <= sat_inc(r_err_cnt);
  end

  assign err_cnt = r_err_cnt;
`endif

endmodule

// File: tb/tb_uart_rx_frame_check.sv
// tb_uart_rx_frame_check: scoreboard bench for uart_rx_frame_check (DATA_WIDTH=8, STOP_BITS=2).
module tb_uart_rx_frame_check;

  localparam int SB = 2;

  logic CLK = 1'b0, RST_n = 1'b0;
  logic frame_en = 1'b0, bit_vld = 1'b0, sampled_bit = 1'b0, par_en = 1'b0, par_typ = 1'b0;
  logic [7:0] p_data;
  logic data_valid, strt_glitch, par_err, stop_err, busy;
`ifdef UART_RX_ERR_CNT_EN
  logic [7:0] err_cnt;
`endif

  uart_rx_frame_check #(.DATA_WIDTH(8), .STOP_BITS(SB)) dut (
    .CLK        (CLK),
    .RST_n      (RST_n),
    .frame_en   (frame_en),
    .bit_vld    (bit_vld),
    .sampled_bit(sampled_bit),
    .par_en     (par_en),
    .par_typ    (par_typ),
    .p_data     (p_data),
    .data_valid (data_valid),
    .strt_glitch(strt_glitch),
    .par_err    (par_err),
    .stop_err   (stop_err),
    .busy       (busy)
`ifdef UART_RX_ERR_CNT_EN
    ,
    .err_cnt    (err_cnt)
`endif
  );

  always #5 CLK = ~CLK;

  typedef struct { int dv, p, eg, ep, es, lat, ec; } exp_t;
  typedef struct { int d, pe, pt, sb, pb, stp, ab, keep, dv, p, eg, ep, es, lat; } vec_t;

  exp_t q[$];
  vec_t vecs[10];
  vec_t v_rst, v_gl;
  int n_tests = 0, n_fail = 0, cyc = 0, ev_cyc = 0, exp_ec = 0;
  logic prev_busy = 1'b0, chk_low = 1'b0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic gap(input int n);
    repeat (n) tick();
  endtask

  // Non-strobe cycles carry the inverted bit so only strobed samples matter
  task automatic strobe(input logic b);
    sampled_bit = b;
    bit_vld = 1'b1;
    tick();
    ev_cyc = cyc;
    bit_vld = 1'b0;
    sampled_bit = ~b;
  endtask

  task automatic run_vec(input vec_t v, input logic npe, input logic npt);
    exp_t e;
    if (v.eg + v.ep + v.es > 0) exp_ec = (exp_ec < 255) ? exp_ec + 1 : 255;
    e = '{v.dv, v.p, v.eg, v.ep, v.es, v.lat, exp_ec};
    q.push_back(e);
    if (!frame_en) begin
      par_en = v.pe[0];
      par_typ = v.pt[0];
      frame_en = 1'b1;
      bit_vld = 1'b1;
      sampled_bit = 1'b1;
      tick();
      bit_vld = 1'b0;
    end
    gap(2);
    strobe(v.sb[0]);
    if (v.sb != 0) begin
      frame_en = 1'b0;
      for (int k = 0; k < 9; k++) begin
        gap(2);
        strobe(k[0]);
      end
      gap(2);
      return;
    end
    par_en = ~v.pe[0];
    par_typ = ~v.pt[0];
    for (int i = 0; i < 8; i++) begin
      gap(2);
      if (i == v.ab) begin
        frame_en = 1'b0;
        tick();
        ev_cyc = cyc;
        gap(2);
        return;
      end
      strobe(v.d[i]);
    end
    if (v.pe != 0) begin
      gap(2);
      strobe(v.pb[0]);
    end
    for (int j = 0; j < SB; j++) begin
      gap(2);
      strobe(v.stp[j]);
    end
    if (v.keep != 0) begin
      par_en = npe;
      par_typ = npt;
    end else begin
      tick();
      frame_en = 1'b0;
    end
    gap(3);
  endtask

  always @(negedge CLK) begin : mon
    exp_t e;
    if (chk_low) begin
      chk("dv_one_cycle", 32'(data_valid), 0);
      chk_low = 1'b0;
    end else if (data_valid && !(prev_busy && !busy)) begin
      chk("dv_unexpected", 32'(data_valid), 0);
    end
    if (prev_busy && !busy) begin
      if (q.size() == 0) begin
        chk("unexpected_frame_end", 32'(busy), 1);
      end else begin
        e = q.pop_front();
        chk("data_valid", 32'(data_valid), e.dv);
        chk("p_data", 32'(p_data), e.p);
        chk("strt_glitch", 32'(strt_glitch), e.eg);
        chk("par_err", 32'(par_err), e.ep);
        chk("stop_err", 32'(stop_err), e.es);
        if (e.lat >= 0) chk("end_latency", cyc - ev_cyc, e.lat);
`ifdef UART_RX_ERR_CNT_EN
        chk("err_cnt", 32'(err_cnt), e.ec);
`endif
        chk_low = data_valid;
      end
    end
    prev_busy = busy;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    // d, pe, pt, sb, pb, stp(bit0 first), abort_at, keep | dv, p, eg, ep, es, lat
    vecs[0] = '{'hA5, 0, 0, 0, 0, 3, -1, 0, 1, 'hA5, 0, 0, 0, 1};
    vecs[1] = '{'h07, 1, 0, 0, 0, 3, -1, 0, 0, 'hA5, 0, 1, 0, 1};
    vecs[2] = '{'h00, 0, 0, 1, 0, 3, -1, 0, 0, 'hA5, 1, 0, 0, 0};
    vecs[3] = '{'h5A, 0, 0, 0, 0, 1, -1, 0, 0, 'hA5, 0, 0, 1, 1};
    vecs[4] = '{'hFF, 0, 0, 0, 0, 3,  4, 0, 0, 'hA5, 0, 0, 0, 0};
    vecs[5] = '{'h3C, 0, 0, 0, 0, 3, -1, 0, 1, 'h3C, 0, 0, 0, 1};
    vecs[6] = '{'h81, 1, 1, 0, 1, 3, -1, 0, 1, 'h81, 0, 0, 0, 1};
    vecs[7] = '{'h96, 1, 0, 0, 0, 3, -1, 1, 1, 'h96, 0, 0, 0, 1};
    vecs[8] = '{'h01, 0, 0, 0, 0, 2, -1, 0, 0, 'h96, 0, 0, 1, 1};
    vecs[9] = '{'h07, 1, 1, 0, 1, 1, -1, 0, 0, 'h96, 0, 1, 1, 1};
    v_rst   = '{'h5A, 1, 0, 0, 0, 3, -1, 0, 1, 'h5A, 0, 0, 0, 1};
    v_gl    = '{'h00, 0, 0, 1, 0, 3, -1, 0, 0, 'h5A, 1, 0, 0, 0};

    gap(3);
    chk("rst_p_data", 32'(p_data), 0);
    chk("rst_data_valid", 32'(data_valid), 0);
    chk("rst_flags", 32'({strt_glitch, par_err, stop_err}), 0);
    chk("rst_busy", 32'(busy), 0);
    RST_n = 1'b1;
    gap(2);

    for (int i = 0; i < 10; i++)
      run_vec(vecs[i], (i < 9) ? vecs[(i < 9) ? i + 1 : i].pe[0] : 1'b0,
              (i < 9) ? vecs[(i < 9) ? i + 1 : i].pt[0] : 1'b0);

    // Asynchronous reset while the FSM waits for the parity bit
    exp_ec = 0;
    q.push_back('{0, 0, 0, 0, 0, -1, 0});
    par_en = 1'b1;
    par_typ = 1'b0;
    frame_en = 1'b1;
    tick();
    gap(2);
    strobe(1'b0);
    for (int i = 0; i < 8; i++) begin
      gap(2);
      strobe(i[0]);
    end
    gap(1);
    chk("busy_before_rst", 32'(busy), 1);
    #2;
    RST_n = 1'b0;
    #1;
    chk("rst_async_busy", 32'(busy), 0);
    chk("rst_async_p_data", 32'(p_data), 0);
    chk("rst_async_flags", 32'({data_valid, strt_glitch, par_err, stop_err}), 0);
    frame_en = 1'b0;
    gap(2);
    RST_n = 1'b1;
    gap(2);
    run_vec(v_rst, 1'b0, 1'b0);

`ifdef UART_RX_ERR_CNT_EN
    for (int i = 0; i < 300; i++) run_vec(v_gl, 1'b0, 1'b0);
    chk("err_cnt_saturated", 32'(err_cnt), 255);
`endif

    gap(5);
    chk("scoreboard_empty", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
